tx_frame_sched: RTL and testbench

TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

---
 rtl/cam_pkg.sv | 19 +
 rtl/tx_frame_sched.sv | 131 +++++++++++++
 tb/tb_tx_frame_sched.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the TX frame scheduler: FSM state encoding and head-word layout.
// The head word carries the data lane in its low bits and the tag directly above it.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_SEND,
    ST_PAD,
    ST_IFG
  } sched_state_t;

  localparam logic TAG_PAYLOAD = 1'b1;

  function automatic int tag_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/tx_frame_sched.sv
// Pulls tagged bytes from a FWFT FIFO and frames them to the MAC with min-length pad and IFG.
// Outputs are combinational on state + FIFO head (same-cycle pop); the MAC stalls only via tx_ack.
module tx_frame_sched
  import cam_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 17,
  parameter int READY_THRESH = 20,
  parameter int MAX_LEN      = 1500,
  parameter int MIN_LEN      = 60,
  parameter int IFG_CYCLES   = 12,
  parameter int TIMEOUT      = 4096
) (
  input  logic              tx_clk,
  input  logic              tx_reset,
  input  logic [DATA_W:0]   fifo_dout,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_valid,
  input  logic              tx_ack,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int TAG   = tag_bit(DATA_W);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  sched_state_t     state;
  logic [LEN_W-1:0] len;
  logic [IFG_W-1:0] ifg_cnt;
  logic [TMR_W-1:0] idle_tmr;

  logic head_vld, head_pay, head_dlm, can_send, len_short, start;

  assign head_vld  = !fifo_empty;
  assign head_pay  = head_vld && (fifo_dout[TAG] == TAG_PAYLOAD);
  assign head_dlm  = head_vld && (fifo_dout[TAG] != TAG_PAYLOAD);
  assign can_send  = head_pay && (len < LEN_W'(MAX_LEN));
  assign len_short = len < LEN_W'(MIN_LEN);
  assign start     = head_pay &&
                     ((fifo_count > CNT_W'(READY_THRESH)) || (idle_tmr == TMR_W'(TIMEOUT)));

  // Every FIFO pop is qualified by head_vld, so an empty FIFO is never read.
  always_comb begin
    fifo_rd_en    = 1'b0;
    tx_data       = '0;
    tx_data_valid = 1'b0;
    if (!tx_reset) begin
      case (state)
        ST_IDLE: fifo_rd_en = head_dlm;
        ST_WAIT_ACK: begin
          tx_data_valid = 1'b1;
          tx_data       = fifo_dout[DATA_W-1:0];
          fifo_rd_en    = tx_ack && head_vld;
        end
        ST_SEND: begin
          if (can_send) begin
            tx_data_valid = 1'b1;
            tx_data       = fifo_dout[DATA_W-1:0];
            fifo_rd_en    = 1'b1;
          end else begin
            fifo_rd_en    = head_dlm;
            tx_data_valid = len_short;
          end
        end
        ST_PAD:  tx_data_valid = len_short;
        default: ;
      endcase
    end
  end

  assign busy = !tx_reset && (state != ST_IDLE);

  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      state       <= ST_IDLE;
      len         <= '0;
      ifg_cnt     <= '0;
      idle_tmr    <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WAIT_ACK;
            idle_tmr <= '0;
          end else if (!head_vld) begin
            idle_tmr <= '0;
          end else if (idle_tmr != TMR_W'(TIMEOUT)) begin
            idle_tmr <= idle_tmr + TMR_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (tx_ack && head_vld) begin
            len   <= LEN_W'(1);
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (can_send || len_short) begin
            len <= len + LEN_W'(1);
            if (!can_send) state <= ST_PAD;
          end else begin
            state       <= ST_IFG;
            ifg_cnt     <= '0;
            frame_count <= frame_count + 16'd1;
          end
        end
        ST_PAD: begin
          if (len_short) begin
            len <= len + LEN_W'(1);
          end else begin
            state       <= ST_IFG;
            ifg_cnt     <= '0;
            frame_count <= frame_count + 16'd1;
          end
        end
        ST_IFG: begin
          if (ifg_cnt == IFG_W'(IFG_CYCLES - 1)) state <= ST_IDLE;
          else ifg_cnt <= ifg_cnt + IFG_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench: queue-based FWFT FIFO model, MAC ack model and frame capture.
module tb_tx_frame_sched;

  localparam int ACK_DELAY = 3;

  logic        tx_clk = 1'b0;
  logic        tx_reset = 1'b1;
  logic [8:0]  fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic [16:0] fifo_count = '0;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_ack = 1'b0;
  logic [15:0] frame_count;
  logic        busy;

  tx_frame_sched dut (
    .tx_clk(tx_clk), .tx_reset(tx_reset),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .fifo_rd_en(fifo_rd_en), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_ack(tx_ack), .frame_count(frame_count), .busy(busy)
  );

  initial forever #5 tx_clk = ~tx_clk;

  logic [8:0] fq[$];
  logic [7:0] cur[$];
  logic [7:0] last_frame[$];
  logic [7:0] exp_q[$];
  bit  pop_pending = 0, in_frame = 0, rst_req = 1;
  int  ack_cnt = 0, frames_done = 0, gap = 0, bgap = 0, last_gap = 0, viol = 0;
  int  n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_count = 17'(fq.size());
    if (fq.size() > 0) fifo_dout = fq[0];
    else fifo_dout = '0;
  endtask

  // One clock: pop what the DUT read at this edge, drive inputs, sample at the falling edge.
  task automatic step();
    @(posedge tx_clk);
    #1;
    if (pop_pending && fq.size() > 0) void'(fq.pop_front());
    tx_reset = rst_req;
    drive_fifo();
    tx_ack = 1'b0;
    #1;
    if (tx_reset) ack_cnt = 0;
    else if (tx_data_valid && !in_frame) begin
      if (ack_cnt == ACK_DELAY) begin
        tx_ack  = 1'b1;
        ack_cnt = 0;
      end else ack_cnt++;
    end
    @(negedge tx_clk);
    pop_pending = fifo_rd_en;
    if (fifo_rd_en && fifo_empty) viol++;
    if (in_frame) begin
      if (tx_data_valid) cur.push_back(tx_data);
      else begin
        in_frame   = 0;
        last_frame = cur;
        cur.delete();
        frames_done++;
        gap  = 1;
        bgap = 1;
      end
    end else if (tx_data_valid && tx_ack) begin
      in_frame = 1;
      cur.delete();
      cur.push_back(tx_data);
      last_gap = gap;
    end else if (!tx_data_valid) begin
      gap++;
      if (busy) bgap++;
    end
  endtask

  task automatic push_pay(input logic [7:0] b);
    fq.push_back({1'b1, b});
  endtask

  task automatic run_until_frames(input int n, input int bound);
    int k = 0;
    while (frames_done < n && k < bound) begin
      step();
      k++;
    end
    chk("frames_seen", frames_done, n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    chk("back_to_idle", busy, 1'b0);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, last_frame.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < last_frame.size(); i++)
      chk(tag, last_frame[i], exp_q[i]);
  endtask

  initial begin
    int n;
    int fd;

    // Reset with a stray delimiter waiting: nothing may be popped until reset drops.
    fq.push_back({1'b0, 8'h55});
    drive_fifo();
    repeat (3) step();
    chk("rst_valid", tx_data_valid, 1'b0);
    chk("rst_rd_en", pop_pending, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_fifo_untouched", fq.size(), 1);
    rst_req = 0;
    repeat (2) step();
    chk("stray_dlm_discarded", fq.size(), 0);
    chk("stray_dlm_no_frame", busy, 1'b0);

    // 30 bytes, ack after 3 cycles: 30 data + 30 pad, then a 12-cycle IFG.
    for (int i = 1; i <= 30; i++) push_pay(8'(i));
    run_until_frames(1, 500);
    exp_q.delete();
    for (int i = 1; i <= 60; i++) exp_q.push_back(i <= 30 ? 8'(i) : 8'h00);
    cmp_frame("t1_byte");
    wait_idle();
    // Terminal no-data cycle of PAD plus the IFG itself.
    chk("t1_busy_gap", bgap, 13);
    chk("t1_frame_count", frame_count, 16'd1);

    // 5 bytes below threshold: the idle timer must saturate before a flush.
    for (int i = 1; i <= 5; i++) push_pay(8'(8'hA0 + i));
    n = 0;
    step();
    while (!tx_data_valid && n < 5000) begin
      n++;
      step();
    end
    chk("t2_idle_cycles", n, 4097);
    run_until_frames(2, 500);
    exp_q.delete();
    for (int i = 1; i <= 60; i++) exp_q.push_back(i <= 5 ? 8'(8'hA0 + i) : 8'h00);
    cmp_frame("t2_byte");
    wait_idle();
    chk("t2_frame_count", frame_count, 16'd2);

    // 2000-byte stream: split at MAX_LEN, second frame resumes at byte 1501.
    for (int i = 1; i <= 2000; i++) push_pay(8'(i));
    run_until_frames(3, 4000);
    exp_q.delete();
    for (int i = 1; i <= 1500; i++) exp_q.push_back(8'(i));
    cmp_frame("t3a_byte");
    chk("t3_left_unread", fq.size(), 500);
    run_until_frames(4, 4000);
    chk("t3_interframe_gap", last_gap, 14);
    exp_q.delete();
    for (int i = 1501; i <= 2000; i++) exp_q.push_back(8'(i));
    cmp_frame("t3b_byte");
    wait_idle();
    chk("t3_frame_count", frame_count, 16'd4);

    // 70 bytes, delimiter, 25 bytes: delimiter closes the frame and is consumed.
    for (int i = 1; i <= 70; i++) push_pay(8'(8'h20 + i));
    fq.push_back({1'b0, 8'hEE});
    for (int i = 1; i <= 25; i++) push_pay(8'(8'hB0 + i));
    run_until_frames(5, 500);
    exp_q.delete();
    for (int i = 1; i <= 70; i++) exp_q.push_back(8'(8'h20 + i));
    cmp_frame("t4a_byte");
    step();
    chk("t4_dlm_popped", fq.size(), 25);
    run_until_frames(6, 500);
    exp_q.delete();
    for (int i = 1; i <= 60; i++) exp_q.push_back(i <= 25 ? 8'(8'hB0 + i) : 8'h00);
    cmp_frame("t4b_byte");
    wait_idle();

    // Reset after the 10th accepted byte aborts the frame.
    for (int i = 1; i <= 40; i++) push_pay(8'(8'h40 + i));
    n = 0;
    while (!(in_frame && cur.size() >= 10) && n < 300) begin
      step();
      n++;
    end
    chk("t5_reached_byte10", cur.size(), 10);
    rst_req = 1;
    step();
    chk("t5_valid_in_reset", tx_data_valid, 1'b0);
    chk("t5_rd_en_in_reset", pop_pending, 1'b0);
    chk("t5_busy_in_reset", busy, 1'b0);
    fq.delete();
    rst_req = 0;
    step();
    chk("t5_frame_count", frame_count, 16'd0);
    chk("t5_valid_after", tx_data_valid, 1'b0);
    fd = frames_done;
    repeat (20) step();
    chk("t5_no_pad_or_ifg", busy, 1'b0);
    chk("t5_no_new_frame", frames_done, fd);

    // FIFO runs dry at byte 80: frame ends there with no pad.
    for (int i = 1; i <= 80; i++) push_pay(8'(i * 3));
    run_until_frames(fd + 1, 500);
    exp_q.delete();
    for (int i = 1; i <= 80; i++) exp_q.push_back(8'(i * 3));
    cmp_frame("t6_byte");
    wait_idle();
    chk("t6_frame_count", frame_count, 16'd1);
    chk("t6_fifo_drained", fq.size(), 0);
    chk("rd_en_while_empty", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
